keypad_scan_decoder: RTL and testbench
======================================

// Module: keypad_scan_decoder
// PURPOSE
//  Input-side counterpart of the 3-digit display multiplexer: drives active-low row strobes
//  of a 4x3 keypad and reads active-low column returns. Debounces, encodes and reports one key
//  per press as a 4-bit code. Feeds the ticket-count entry/control logic.
// PARAMETERS
//  SCAN_DIV        165000  clk cycles per row dwell; sample tick at end of each dwell
//  DEBOUNCE_SCANS  4       consecutive matching sample ticks needed for press and for release
//  REPEAT_TICKS    64      sample ticks between auto-repeat pulses (used only with KEY_REPEAT_EN)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous reset, active-high
//  col_n      in   3  keypad column returns, active-low, asynchronous (pulled up off-chip)
//  row_n      out  4  row strobes, active-low, exactly one low at any time
//  key_code   out  4  encoded key; holds last value until next press
//  key_valid  out  1  one-cycle pulse when key_code updates
//  key_held   out  1  high from the key_valid pulse until release debounce completes
// BEHAVIOUR
//  - Reset: row_n=4'b1110, key_code=0, key_valid=0, key_held=0, FSM=SCAN, all counters 0.
//  - col_n passes a 2-flop synchroniser; all decisions use the synchronised value.
//  - Prescaler counts 0..SCAN_DIV-1; tick = (count==SCAN_DIV-1); wraps to 0.
//  - Column select: lowest-index low column wins; colhit = any column low.
//  - Code map: rows 0-2 -> row*3+col+1 (1..9); row 3: col0=10 (STAR), col1=0, col2=11 (HASH).
//  - FSM, evaluated on tick only (no state/row change between ticks):
//    SCAN: colhit -> latch row/col, deb=1, go PRESS, row frozen; else rotate row 0->1->2->3->0.
//    PRESS: same col low -> deb++; deb reaching DEBOUNCE_SCANS -> key_code/key_valid/key_held,
//           go HELD. Mismatch or no hit -> deb=0, go SCAN, advance row. DEBOUNCE_SCANS=1:
//           key_valid issues on the first hit tick.
//    HELD: all columns high -> deb=1, go RELEASE; else stay.
//    RELEASE: all high -> deb++; deb reaching DEBOUNCE_SCANS -> key_held=0, go SCAN, next row.
//             Any low -> go HELD, deb=0.
//  - Latency: key_valid rises the clk cycle after the tick that completes press debounce.
//  - Second key pressed while HELD is ignored; only the latched key's release is tracked.
//  - rst mid-operation aborts any state; no key_valid pulse on the reset cycle or the one after.
//  - Counters sized by $clog2; deb saturates, never wraps.
// CONFIGURATION
//  KEY_REPEAT_EN defined: in HELD, after REPEAT_TICKS ticks, key_valid pulses again with the
//   same code, repeating every REPEAT_TICKS ticks until release begins; counter clears on
//   entry to HELD.
//  KEY_REPEAT_EN undefined: exactly one key_valid per press; REPEAT_TICKS unused, no counter.
// STRUCTURE
//  Package keypad_pkg: FSM state enum (SCAN, PRESS, HELD, RELEASE), KEY_STAR=4'd10,
//   KEY_HASH=4'd11, ROWS=4, COLS=3.
//  Sub-module scan_tick_gen: parameterised prescaler producing the one-cycle tick.
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_TICKS=3)
//  1 Reset, no keys: row_n cycles 1110,1101,1011,0111 every 4 clks; key_valid never asserted.
//  2 Hold row1/col2 (key 6) 10 ticks, then release: one key_valid, key_code=6, key_held
//    drops 2 ticks after release.
//  3 Bounce: key low 1 tick, high 1 tick, repeated 5 times -> no key_valid; scan resumes.
//  4 Row3 col0 and col2 together -> key_code=10 (lowest column); row3 col1 alone -> code 0.
//  5 rst asserted during PRESS -> outputs at reset values the next cycle; re-press reports key.
//  6 KEY_REPEAT_EN: hold key 9 for 12 ticks -> key_valid at debounce, then every 3 ticks, code 9.

Source files
------------

// File: rtl/keypad_scan_decoder_pkg.sv
// Shared types and constants for the 4x3 keypad scanner: FSM states, special key codes
// and the row/column to key-code map.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 3;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        SCAN,
        PRESS,
        HELD,
        RELEASE
    } kp_state_t;

    // Rows 0-2 are the digit rows 1..9; the bottom row carries STAR, 0 and HASH.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        if (row == 2'd3) begin
            case (col)
                2'd0:    return KEY_STAR;
                2'd1:    return 4'd0;
                default: return KEY_HASH;
            endcase
        end
        return 4'(row * 3 + col + 1);
    endfunction

endpackage

// File: rtl/keypad_scan_decoder_if.sv
// Keypad-side and key-report signals of the scan decoder, grouped for port connection.
interface keypad_scan_decoder_if;
    import keypad_pkg::*;

    logic [COLS-1:0] col_n;
    logic [ROWS-1:0] row_n;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            key_held;

    modport master (
        input  col_n,
        output row_n,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output col_n,
        input  row_n,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_scan_decoder_scan_tick_gen.sv
// Free-running prescaler: one-cycle tick every SCAN_DIV clocks, marking the end of a row dwell.
module scan_tick_gen #(
    parameter int SCAN_DIV = 165000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x3 keypad scanner: row strobing, debounced press/release tracking and key encoding.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module keypad_scan_decoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 165000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_TICKS   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_scan_decoder_if.master kp
);

    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_SCANS);

    if (DEBOUNCE_SCANS < 1 || REPEAT_TICKS < 1) begin : g_cfg_err
        $error("keypad_scan_decoder: DEBOUNCE_SCANS and REPEAT_TICKS must be >= 1");
    end

    function automatic logic [DEB_W-1:0] deb_sat_inc(input logic [DEB_W-1:0] v);
        return (v == DEB_MAX) ? v : v + 1'b1;
    endfunction

    logic            tick;
    logic [COLS-1:0] col_sync_p0, col_sync_p1;
    logic            colhit;
    logic [1:0]      col_sel;
    kp_state_t       state, state_nxt;
    logic [1:0]      row, row_nxt;
    logic [1:0]      col_lat, col_lat_nxt;
    logic [DEB_W-1:0] deb, deb_nxt, deb_inc;
    logic [3:0]      code, code_nxt;
    logic            valid, valid_nxt;
    logic            held, held_nxt;
    logic            take, done;

`ifdef KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
    logic [REP_W-1:0] rep, rep_nxt;
`endif

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Stage p0/p1: two-flop synchroniser for the asynchronous column returns
    always_ff @(posedge clk) begin
        col_sync_p0 <= kp.col_n;
        col_sync_p1 <= col_sync_p0;
    end

    assign colhit = ~&col_sync_p1;

    always_comb begin
        col_sel = 2'd2;
        if (!col_sync_p1[0]) begin
            col_sel = 2'd0;
        end else if (!col_sync_p1[1]) begin
            col_sel = 2'd1;
        end
    end

    always_comb begin
        state_nxt   = state;
        row_nxt     = row;
        col_lat_nxt = col_lat;
        deb_nxt     = deb;
        code_nxt    = code;
        valid_nxt   = 1'b0;
        held_nxt    = held;
        take        = 1'b0;
        done        = 1'b0;
        deb_inc     = deb_sat_inc(deb);
`ifdef KEY_REPEAT_EN
        rep_nxt     = rep;
`endif
        if (tick) begin
            case (state)
                SCAN: begin
                    if (colhit) begin
                        col_lat_nxt = col_sel;
                        deb_nxt     = DEB_W'(1);
                        if (DEB_MAX == DEB_W'(1)) take = 1'b1;
                        else                      state_nxt = PRESS;
                    end else begin
                        row_nxt = row + 1'b1;
                    end
                end
                PRESS: begin
                    if (colhit && col_sel == col_lat) begin
                        deb_nxt = deb_inc;
                        take    = (deb_inc == DEB_MAX);
                    end else begin
                        deb_nxt   = '0;
                        state_nxt = SCAN;
                        row_nxt   = row + 1'b1;
                    end
                end
                HELD: begin
                    if (!colhit) begin
                        deb_nxt = DEB_W'(1);
                        if (DEB_MAX == DEB_W'(1)) done = 1'b1;
                        else                      state_nxt = RELEASE;
                    end
`ifdef KEY_REPEAT_EN
                    else if (rep == REP_LAST) begin
                        rep_nxt   = '0;
                        valid_nxt = 1'b1;
                    end else begin
                        rep_nxt = rep + 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    if (!colhit) begin
                        deb_nxt = deb_inc;
                        done    = (deb_inc == DEB_MAX);
                    end else begin
                        deb_nxt   = '0;
                        state_nxt = HELD;
`ifdef KEY_REPEAT_EN
                        rep_nxt   = '0;
`endif
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
        // The row stays frozen from first hit until release completes
        if (take) begin
            code_nxt  = key_map(row, col_sel);
            valid_nxt = 1'b1;
            held_nxt  = 1'b1;
            state_nxt = HELD;
`ifdef KEY_REPEAT_EN
            rep_nxt   = '0;
`endif
        end
        if (done) begin
            held_nxt  = 1'b0;
            state_nxt = SCAN;
            row_nxt   = row + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SCAN;
            row   <= 2'd0;
            deb   <= '0;
            code  <= 4'd0;
            valid <= 1'b0;
            held  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep   <= '0;
`endif
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            deb   <= deb_nxt;
            code  <= code_nxt;
            valid <= valid_nxt;
            held  <= held_nxt;
`ifdef KEY_REPEAT_EN
            rep   <= rep_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        col_lat <= col_lat_nxt;
    end

    assign kp.row_n     = ~(4'b0001 << row);
    assign kp.key_code  = code;
    assign kp.key_valid = valid;
    assign kp.key_held  = held;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Bench for keypad_scan_decoder: a physical 4x3 keypad model driven by row_n, a per-cycle
// reference model of the scanning rules, directed scenarios and randomized key episodes.
module tb_keypad_scan_decoder;

    localparam int SD  = 4;
    localparam int DEB = 2;
    localparam int REP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [11:0] keys = '0;
    logic [2:0]  col_drv;

    keypad_scan_decoder_if kif ();

    keypad_scan_decoder #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_TICKS   (REP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    always #5 clk = ~clk;

    // A pressed key connects its row strobe to its column return
    always_comb begin
        col_drv = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!kif.row_n[r] && keys[r*3+c]) col_drv[c] = 1'b0;
    end
    assign kif.col_n = col_drv;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_valid = 0;
    int n_print = 0;

    // Reference model: what the outputs must be after each clock edge
    logic [2:0] h1 = 3'b111, h2 = 3'b111, seen;
    int   m_cnt, m_row, m_phase, m_run, m_col, m_rep, fc;
    logic [3:0] m_code;
    logic m_valid, m_held;
    bit   m_live = 1'b0;

    function automatic int keyval(input int r, input int c);
        if (r < 3) return r * 3 + c + 1;
        return (c == 0) ? 10 : (c == 1) ? 0 : 11;
    endfunction

    task m_accept;
        m_code  = 4'(keyval(m_row, m_col));
        m_valid = 1'b1;
        m_held  = 1'b1;
        m_phase = 2;
        m_rep   = 0;
    endtask

    task m_finish_release;
        m_held  = 1'b0;
        m_phase = 0;
        m_row   = (m_row + 1) % 4;
    endtask

    always @(posedge clk) begin
        seen = h2;
        h2   = h1;
        h1   = kif.col_n;
        if (rst) begin
            m_cnt = 0; m_row = 0; m_phase = 0; m_run = 0; m_col = 0; m_rep = 0;
            m_code = 4'd0; m_valid = 1'b0; m_held = 1'b0; m_live = 1'b1;
        end else begin
            m_valid = 1'b0;
            if (m_cnt == SD - 1) begin
                m_cnt = 0;
                fc = !seen[0] ? 0 : !seen[1] ? 1 : !seen[2] ? 2 : -1;
                case (m_phase)
                    0: if (fc >= 0) begin
                           m_col = fc; m_run = 1;
                           if (m_run >= DEB) m_accept(); else m_phase = 1;
                       end else m_row = (m_row + 1) % 4;
                    1: if (fc == m_col) begin
                           m_run++;
                           if (m_run >= DEB) m_accept();
                       end else begin
                           m_run = 0; m_phase = 0; m_row = (m_row + 1) % 4;
                       end
                    2: if (fc < 0) begin
                           m_run = 1;
                           if (m_run >= DEB) m_finish_release(); else m_phase = 3;
                       end else begin
`ifdef KEY_REPEAT_EN
                           m_rep++;
                           if (m_rep == REP) begin m_valid = 1'b1; m_rep = 0; end
`endif
                       end
                    default: if (fc < 0) begin
                           m_run++;
                           if (m_run >= DEB) m_finish_release();
                       end else begin
                           m_run = 0; m_phase = 2; m_rep = 0;
                       end
                endcase
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_row_n;
        if (m_live) begin
            exp_row_n = ~(4'b0001 << m_row);
            n_cmp++;
            if (kif.row_n !== exp_row_n || kif.key_code !== m_code ||
                kif.key_valid !== m_valid || kif.key_held !== m_held) begin
                n_bad++;
                if (n_print < 20) begin
                    n_print++;
                    $display("FAIL cycle_model t=%0t row_n/code/valid/held got %b/%0d/%b/%b want %b/%0d/%b/%b",
                             $time, kif.row_n, kif.key_code, kif.key_valid, kif.key_held,
                             exp_row_n, m_code, m_valid, m_held);
                end
            end
            if (kif.key_valid === 1'b1) n_valid++;
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * SD) @(negedge clk);
        #1;
    endtask

    logic [3:0] rows_exp [4];
    logic [3:0] r0;
    int v0, rr, cc, found;

    initial begin
        rows_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // 1: reset values and idle scanning
        repeat (3) @(negedge clk);
        #1;
        check("reset_row_n", kif.row_n, 4'b1110);
        check("reset_code", kif.key_code, 0);
        check("reset_valid", kif.key_valid, 0);
        check("reset_held", kif.key_held, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (SD) @(negedge clk);
            #1;
            check("scan_row_n", kif.row_n, rows_exp[i]);
        end
        check("idle_no_valid", n_valid, 0);

        // 2: key 6 held for 10 ticks, then released
        v0 = n_valid;
        keys[1*3+2] = 1'b1;
        wait_ticks(10);
        check("key6_code", kif.key_code, 6);
        check("key6_held", kif.key_held, 1);
        check("key6_one_valid", n_valid - v0, 1);
        keys = '0;
        wait_ticks(1);
        check("key6_held_after_1tick", kif.key_held, 1);
        wait_ticks(2);
        check("key6_released", kif.key_held, 0);
        check("key6_total_valid", n_valid - v0, 1);

        // 3: bouncing key 5 never qualifies, scanning continues
        v0 = n_valid;
        for (int i = 0; i < 5; i++) begin
            keys[1*3+1] = 1'b1;
            repeat (SD) @(negedge clk);
            keys = '0;
            repeat (SD) @(negedge clk);
        end
        wait_ticks(3);
        check("bounce_no_valid", n_valid - v0, 0);
        check("bounce_not_held", kif.key_held, 0);
        r0 = kif.row_n;
        wait_ticks(1);
        check("bounce_scan_resumes", kif.row_n, {r0[2:0], r0[3]});

        // 5: reset in the middle of press debounce for key 7
        found = 0;
        for (int i = 0; i < 64 && found == 0; i++) begin
            @(negedge clk);
            if (kif.row_n != 4'b1011) found = 1;
        end
        keys[2*3+0] = 1'b1;
        found = 0;
        for (int i = 0; i < 64 && found == 0; i++) begin
            @(negedge clk);
            if (kif.row_n == 4'b1011) found = 1;
        end
        check("press_row_reached", found, 1);
        v0 = n_valid;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_row_n", kif.row_n, 4'b1110);
        check("midrst_code", kif.key_code, 0);
        check("midrst_valid", kif.key_valid, 0);
        check("midrst_held", kif.key_held, 0);
        @(negedge clk);
        #1;
        check("midrst_valid_next", kif.key_valid, 0);
        rst = 1'b0;
        check("midrst_no_valid", n_valid - v0, 0);
        wait_ticks(12);
        check("repress_code", kif.key_code, 7);
        check("repress_one_valid", n_valid - v0, 1);
        keys = '0;
        wait_ticks(4);

        // 4: STAR wins over HASH in the bottom row, then key 0 alone
        v0 = n_valid;
        keys[3*3+0] = 1'b1;
        keys[3*3+2] = 1'b1;
        wait_ticks(10);
        check("star_code", kif.key_code, 10);
        check("star_one_valid", n_valid - v0, 1);
        keys = '0;
        wait_ticks(4);
        v0 = n_valid;
        keys[3*3+1] = 1'b1;
        wait_ticks(10);
        check("zero_code", kif.key_code, 0);
        check("zero_held", kif.key_held, 1);
        check("zero_one_valid", n_valid - v0, 1);
        keys = '0;
        wait_ticks(4);

`ifdef KEY_REPEAT_EN
        // 6: key 9 held with auto-repeat every REP ticks
        keys[2*3+2] = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (kif.key_valid === 1'b1) found = 1;
        end
        check("repeat_first_valid", found, 1);
        #1;
        v0 = n_valid;
        wait_ticks(12);
        check("repeat_pulses", n_valid - v0, 4);
        check("repeat_code", kif.key_code, 9);
        keys = '0;
        wait_ticks(4);
`endif

        // Randomized episodes: single keys, occasional second key, bounces and resets
        for (int e = 0; e < 40; e++) begin
            rr = $urandom_range(0, 3);
            cc = $urandom_range(0, 2);
            keys[rr*3+cc] = 1'b1;
            if ($urandom_range(0, 4) == 0) keys[$urandom_range(0, 11)] = 1'b1;
            repeat ($urandom_range(1, 48)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                keys = '0;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                keys[rr*3+cc] = 1'b1;
                repeat ($urandom_range(1, 16)) @(negedge clk);
            end
            keys = '0;
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 24)) @(negedge clk);
        end
        wait_ticks(6);
        check("final_not_held", kif.key_held, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
